// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default bit period and byte width.
// Also used by the transmit side of audioEngine.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 40;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with a registered output stage.
// The output register counts toward DEPTH, so the FIFO holds exactly DEPTH bytes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [AW:0]       mem_count;
  logic [AW+1:0]     total_count;
  logic [BYTE_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              pop;
  logic              push;
  logic              load;

  assign mem_count   = wr_ptr_reg - rd_ptr_reg;
  assign total_count = {1'b0, mem_count} + {{(AW + 1){1'b0}}, out_valid_reg};
  assign full        = (total_count == (AW + 2)'(DEPTH));
  assign pop         = rd_en && out_valid_reg;
  // A write into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push        = wr_en && (!full || pop);
  assign load        = (mem_count != '0) && (!out_valid_reg || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      end
      if (load) begin
        out_data_reg  <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg    <= rd_ptr_reg + (AW + 1)'(1);
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign rd_data  = out_data_reg;
  assign rd_valid = out_valid_reg;

endmodule

// File: rtl/uart_rx_link.sv
// 8N1 UART receiver with ready/valid output. Define UART_RX_FIFO_EN to buffer
// received bytes in a FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_rx_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ftdi_rx,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  uart_state_t       state_reg;
  logic [1:0]        sync_reg;
  logic              prev_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [BYTE_W-1:0] shift_reg;
  logic              commit_reg;
  logic [BYTE_W-1:0] commit_data_reg;
  logic              frame_err_reg;
  logic              line;
  logic              pop;

  assign line = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg        <= 2'b11;
      prev_reg        <= 1'b1;
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      commit_reg      <= 1'b0;
      commit_data_reg <= '0;
      frame_err_reg   <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], ftdi_rx};
      prev_reg      <= line;
      commit_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (prev_reg && !line) begin
            state_reg <= ST_START;
            cnt_reg   <= '0;
          end
        end
        ST_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= line ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {line, shift_reg[BYTE_W-1:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (line) begin
              commit_reg      <= 1'b1;
              commit_data_reg <= shift_reg;
              state_reg       <= ST_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (line) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign frame_err = frame_err_reg;
  assign pop       = rx_valid && rx_ready;

  // Empty block whose name flags an illegal depth in elaboration reports.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_not_pow2
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_full;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (commit_reg),
    .wr_data (commit_data_reg),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .rd_valid(rx_valid),
    .full    (fifo_full)
  );

  assign overrun = commit_reg && fifo_full && !pop;
`else
  logic [BYTE_W-1:0] hold_data_reg;
  logic              hold_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_reg  <= '0;
      hold_valid_reg <= 1'b0;
    end else if (commit_reg && (!hold_valid_reg || pop)) begin
      hold_data_reg  <= commit_data_reg;
      hold_valid_reg <= 1'b1;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign rx_data  = hold_data_reg;
  assign rx_valid = hold_valid_reg;
  assign overrun  = commit_reg && hold_valid_reg && !pop;
`endif

endmodule

// File: tb/tb_uart_rx_link.sv
// Randomized self-checking bench for uart_rx_link against a byte-queue reference model.
module tb_uart_rx_link;

  localparam int CPB = 40;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 16;
  localparam int LAT = 2;
`else
  localparam int CAP = 1;
  localparam int LAT = 1;
`endif
  // Start edge to stop mid-sample: 2 sync flops, 1 edge-detect cycle, half a bit, 9 bits.
  localparam int STOP_MID = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ftdi_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_link #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ftdi_rx  (ftdi_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #4 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes that must come out, in order, plus event tallies.
  logic [7:0]  expected_q[$];
  int          ready_mode = 1;
  int          ferr_count = 0;
  int          ovr_count = 0;
  int          rx_count = 0;
  int unsigned ferr_cyc = 0;
  int unsigned ovr_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned last_start = 0;
  logic        prev_hold = 1'b0;
  logic        prev_valid = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (frame_err) begin
        ferr_count++;
        ferr_cyc = cyc;
      end
      if (overrun) begin
        ovr_count++;
        ovr_cyc = cyc;
      end
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (prev_hold) begin
        check_value("hold_valid", 32'(rx_valid), 32'd1);
        check_value("hold_data", 32'(rx_data), 32'(prev_data));
      end
      if (rx_valid && rx_ready) begin
        if (expected_q.size() == 0) begin
          check_value("spurious_valid", 32'(rx_valid), 32'd0);
        end else begin
          check_value("rx_byte", 32'(rx_data), 32'(expected_q.pop_front()));
          rx_count++;
        end
      end
      prev_hold  = rx_valid && !rx_ready;
      prev_data  = rx_data;
      prev_valid = rx_valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; returns at #1 after an edge with the stop level left on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    last_start = cyc;
    ftdi_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      ftdi_rx = b[i];
      wait_cycles(CPB);
    end
    ftdi_rx = stop;
    wait_cycles(CPB);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (expected_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    wait_cycles(3);
    check_value(tag, 32'(expected_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int saved;
    int exp_ferr;

    // Reset state
    wait_cycles(5);
    check_value("rst_rx_data", 32'(rx_data), 32'd0);
    check_value("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_value("rst_frame_err", 32'(frame_err), 32'd0);
    check_value("rst_overrun", 32'(overrun), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_cycles(5);

    // Single byte 0xA5 with exact latency
    expected_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_cycles(10);
    check_value("a5_latency", rise_cyc - last_start, 32'(STOP_MID + LAT));
    check_value("a5_frame_err", 32'(ferr_count), 32'd0);
    wait_drain("a5_drain", 50);
    check_value("a5_busy", 32'(busy), 32'd0);

    // 10-cycle low glitch is rejected
    saved = rx_count;
    ftdi_rx = 1'b0;
    wait_cycles(10);
    ftdi_rx = 1'b1;
    wait_cycles(5);
    check_value("glitch_busy_start", 32'(busy), 32'd1);
    wait_cycles(CPB);
    check_value("glitch_busy_idle", 32'(busy), 32'd0);
    check_value("glitch_no_byte", 32'(rx_count), 32'(saved));

    // Bad stop bit, line held low, then recovery
    ferr_count = 0;
    send_frame(8'h3C, 1'b0);
    wait_cycles(200);
    ftdi_rx = 1'b1;
    wait_cycles(6);
    check_value("ferr_count", 32'(ferr_count), 32'd1);
    check_value("ferr_cycle", ferr_cyc - last_start, 32'(STOP_MID));
    check_value("ferr_busy", 32'(busy), 32'd0);
    check_value("ferr_no_byte", 32'(expected_q.size()), 32'd0);
    expected_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain("ferr_recover", 50);
    check_value("ferr_single", 32'(ferr_count), 32'd1);

    // Overrun: consumer stalled, one byte more than storage
    ready_mode = 0;
    ovr_count = 0;
    wait_cycles(2);
    for (int i = 0; i <= CAP; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < CAP) expected_q.push_back(b);
      send_frame(b, 1'b1);
    end
    wait_cycles(5);
    check_value("ovr_count", 32'(ovr_count), 32'd1);
    check_value("ovr_cycle", ovr_cyc - last_start, 32'(STOP_MID));
    check_value("ovr_valid_held", 32'(rx_valid), 32'd1);
    ready_mode = 1;
    wait_drain("ovr_drain", CAP * 4 + 20);

    // Back-to-back frames
    ferr_count = 0;
    ovr_count = 0;
    expected_q.push_back(8'h00);
    expected_q.push_back(8'hFF);
    expected_q.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    wait_drain("b2b_drain", 50);
    check_value("b2b_ferr", 32'(ferr_count), 32'd0);
    check_value("b2b_ovr", 32'(ovr_count), 32'd0);

    // Reset during data bit 4 aborts the frame
    saved = rx_count;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_cycles(5 * CPB + 10);
        rst = 1'b1;
        wait_cycles(3);
        check_value("rst_mid_valid", 32'(rx_valid), 32'd0);
        check_value("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
      end
    join
    wait_cycles(20);
    check_value("rst_mid_no_byte", 32'(rx_count), 32'(saved));
    expected_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_drain("rst_mid_7e", 50);

    // Randomized traffic with random consumer stalls and occasional bad stop bits
    ready_mode = 2;
    ferr_count = 0;
    ovr_count = 0;
    exp_ferr = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1'b0);
        wait_cycles(20);
        ftdi_rx = 1'b1;
        wait_cycles(5);
        exp_ferr++;
      end else begin
        expected_q.push_back(b);
        send_frame(b, 1'b1);
      end
      wait_cycles($urandom_range(0, 30));
    end
    wait_drain("rand_drain", 200);
    check_value("rand_ferr", 32'(ferr_count), 32'(exp_ferr));
    check_value("rand_ovr", 32'(ovr_count), 32'd0);
    check_value("rand_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
